// File: rtl/riscv_pkg.sv
// Types and sizing shared by the instruction-memory path of the core.
// The loader FSM encoding lives here so the core and loader agree on it.
package riscv_pkg;

   localparam int IMEM_ADDR_W = 6;
   localparam int IMEM_DEPTH  = 64;
   localparam int LOAD_LEN_W  = 7;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE
   } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Host-byte, CPU-fetch and instruction-memory signals of the loader.
// The master side is the host/CPU/memory; the slave side is the loader.
interface imem_loader_if #(
   parameter int IMEM_ADDR_W = riscv_pkg::IMEM_ADDR_W
);

   logic                              start;
   logic [riscv_pkg::LOAD_LEN_W-1:0]  load_len;
   logic                              byte_valid;
   logic [7:0]                        byte_data;
   logic                              byte_ready;
   logic [7:0]                        cpu_pc;
   logic [IMEM_ADDR_W-1:0]            mem_raddr;
   logic                              mem_we;
   logic [IMEM_ADDR_W-1:0]            mem_waddr;
   logic [31:0]                       mem_wdata;
   logic                              cpu_stall;
   logic                              busy;
   logic                              done;
   logic                              fetch_fault;

   modport master (
      output start, load_len, byte_valid, byte_data, cpu_pc,
      input  byte_ready, mem_raddr, mem_we, mem_waddr, mem_wdata,
             cpu_stall, busy, done, fetch_fault
   );

   modport slave (
      input  start, load_len, byte_valid, byte_data, cpu_pc,
      output byte_ready, mem_raddr, mem_we, mem_waddr, mem_wdata,
             cpu_stall, busy, done, fetch_fault
   );

endinterface

// File: rtl/byte_packer.sv
// Assembles four accepted host bytes into one little-endian 32-bit word.
// word_last flags the accept that completes a word so the FSM can write it.
module byte_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_last
);

   logic [1:0] count;

   assign word_last = accept && (count == 2'd3);

   // Idle cycles between accepts leave count and the partial word untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 2'd0;
         word  <= 32'd0;
      end else if (accept) begin
         word[{count, 3'b000} +: 8] <= byte_data;
         count                      <= count + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams host bytes into instruction memory while holding the CPU stalled,
// and arbitrates the memory read port between the loader and CPU fetch.
module imem_loader #(
   parameter int IMEM_ADDR_W = riscv_pkg::IMEM_ADDR_W,
   parameter int IMEM_DEPTH  = riscv_pkg::IMEM_DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   imem_loader_if.slave  bus
);

   import riscv_pkg::*;

   localparam logic [LOAD_LEN_W-1:0] DEPTH_LEN = LOAD_LEN_W'(IMEM_DEPTH);
   localparam logic [8:0]            DEPTH_PC  = 9'(IMEM_DEPTH);

   loader_state_t         state;
   logic [LOAD_LEN_W-1:0] word_idx;
   logic [LOAD_LEN_W-1:0] len_q;
   logic                  byte_ready_q;
   logic                  mem_we_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  accept;
   logic                  word_last;
   logic [31:0]           packed_word;

   assign accept = bus.byte_valid && byte_ready_q;

   byte_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .accept    (accept),
      .byte_data (bus.byte_data),
      .word      (packed_word),
      .word_last (word_last)
   );

   // Outputs are registered alongside the state so each one is glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         word_idx     <= '0;
         len_q        <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         done_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  word_idx <= '0;
                  len_q    <= (bus.load_len > DEPTH_LEN) ? DEPTH_LEN : bus.load_len;
                  busy_q   <= 1'b1;
                  if (bus.load_len == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state        <= LOAD;
                     byte_ready_q <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (word_last) begin
                  state        <= WRITE;
                  byte_ready_q <= 1'b0;
                  mem_we_q     <= 1'b1;
               end
            end
            WRITE: begin
               word_idx <= word_idx + LOAD_LEN_W'(1);
               if (word_idx + LOAD_LEN_W'(1) == len_q) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  state        <= LOAD;
                  byte_ready_q <= 1'b1;
               end
            end
            DONE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_waddr  = word_idx[IMEM_ADDR_W-1:0];
   assign bus.mem_wdata  = packed_word;
   assign bus.busy       = busy_q;
   assign bus.cpu_stall  = busy_q;
   assign bus.done       = done_q;
   assign bus.mem_raddr  = busy_q ? word_idx[IMEM_ADDR_W-1:0] : bus.cpu_pc[IMEM_ADDR_W-1:0];

   // Gated by rst_n so every output except the read address is low in reset.
   assign bus.fetch_fault = rst_n && !busy_q && ({1'b0, bus.cpu_pc} >= DEPTH_PC);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes are queued as bytes are
// driven and retired by a negedge monitor watching mem_we.
module tb_imem_loader;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   imem_loader_if #(.IMEM_ADDR_W(6)) bus ();

   imem_loader #(.IMEM_ADDR_W(6), .IMEM_DEPTH(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];
   wr_t monExp;
   int  assertCount = 0;
   int  failCount   = 0;
   int  cycleCnt    = 0;
   int  weCount     = 0;
   int  doneSeen    = 0;
   int  doneCycle   = 0;

   logic [7:0] t1Bytes [0:7] = '{8'h13, 8'h03, 8'h71, 8'h02, 8'h97, 8'h83, 8'h00, 8'h00};

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Every write strobe retires the oldest expected write.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) begin
         weCount++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_write", 32'd1, 32'd0);
         end else begin
            monExp = sb.pop_front();
            checkOutput("write_addr", 32'(bus.mem_waddr), 32'(monExp.addr));
            checkOutput("write_data", bus.mem_wdata, monExp.data);
         end
      end
      if (bus.done === 1'b1) begin
         doneSeen++;
         doneCycle = cycleCnt;
      end
   end

   task automatic applyStimulus(input logic [6:0] len, output int startC);
      bus.start    = 1'b1;
      bus.load_len = len;
      startC       = cycleCnt;
      @(posedge clk); #1;
      bus.start    = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input int gap);
      int guard;
      guard = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (bus.byte_ready !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 20) checkOutput("byte_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      bus.byte_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic sendWord(input logic [31:0] w);
      for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8], 0);
   endtask

   task automatic waitDone(input int prev, input string tag);
      int n;
      n = 0;
      while (doneSeen == prev && n < 400) begin
         @(posedge clk); #2;
         n++;
      end
      checkOutput(tag, 32'(doneSeen - prev), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sc;
      int we0;
      int d0;
      logic [31:0] w;

      bus.start      = 1'b0;
      bus.load_len   = 7'd0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      bus.cpu_pc     = 8'h95;
      rst_n          = 1'b0;
      #12;

      // Reset state: outputs low, read address follows cpu_pc
      checkOutput("rst_busy",        32'(bus.busy),        32'd0);
      checkOutput("rst_cpu_stall",   32'(bus.cpu_stall),   32'd0);
      checkOutput("rst_byte_ready",  32'(bus.byte_ready),  32'd0);
      checkOutput("rst_mem_we",      32'(bus.mem_we),      32'd0);
      checkOutput("rst_done",        32'(bus.done),        32'd0);
      checkOutput("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
      checkOutput("rst_mem_waddr",   32'(bus.mem_waddr),   32'd0);
      checkOutput("rst_mem_wdata",   bus.mem_wdata,        32'd0);
      checkOutput("rst_mem_raddr",   32'(bus.mem_raddr),   32'h15);
      @(posedge clk); #1;
      rst_n      = 1'b1;
      bus.cpu_pc = 8'h00;
      @(posedge clk); #1;

      $display("[TB] two-word load with back-to-back bytes");
      sb.push_back(wr_t'{6'd0, 32'h02710313});
      sb.push_back(wr_t'{6'd1, 32'h00008397});
      bus.cpu_pc = 8'hFF;
      d0  = doneSeen;
      we0 = weCount;
      applyStimulus(7'd2, sc);
      checkOutput("t1_busy",        32'(bus.busy),        32'd1);
      checkOutput("t1_cpu_stall",   32'(bus.cpu_stall),   32'd1);
      checkOutput("t1_byte_ready",  32'(bus.byte_ready),  32'd1);
      checkOutput("t1_fetch_fault", 32'(bus.fetch_fault), 32'd0);
      checkOutput("t1_mem_raddr",   32'(bus.mem_raddr),   32'd0);
      for (int i = 0; i < 8; i++) sendByte(t1Bytes[i], 0);
      waitDone(d0, "t1_done");
      checkOutput("t1_done_cycle", 32'(doneCycle - sc),   32'd11);
      checkOutput("t1_writes",     32'(weCount - we0),    32'd2);
      checkOutput("t1_sb_empty",   32'(sb.size()),        32'd0);
      checkOutput("t1_busy_after", 32'(bus.busy),         32'd0);
      bus.cpu_pc = 8'h00;

      $display("[TB] zero-length load");
      @(posedge clk); #1;
      d0  = doneSeen;
      we0 = weCount;
      applyStimulus(7'd0, sc);
      checkOutput("t2_done",      32'(bus.done),      32'd1);
      checkOutput("t2_busy",      32'(bus.busy),      32'd1);
      checkOutput("t2_cpu_stall", 32'(bus.cpu_stall), 32'd1);
      @(posedge clk); #1;
      checkOutput("t2_done_low",  32'(bus.done),      32'd0);
      checkOutput("t2_busy_low",  32'(bus.busy),      32'd0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      checkOutput("t2_no_write",   32'(weCount - we0),  32'd0);
      checkOutput("t2_one_done",   32'(doneSeen - d0),  32'd1);
      checkOutput("t2_done_cycle", 32'(doneCycle - sc), 32'd1);

      $display("[TB] oversize length clamps to memory depth");
      d0  = doneSeen;
      we0 = weCount;
      applyStimulus(7'd100, sc);
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         sb.push_back(wr_t'{6'(i), w});
         sendWord(w);
      end
      waitDone(d0, "t3_done");
      checkOutput("t3_writes",   32'(weCount - we0), 32'd64);
      checkOutput("t3_sb_empty", 32'(sb.size()),     32'd0);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h5A;
      repeat (8) begin
         @(posedge clk); #1;
      end
      checkOutput("t3_idle_ready", 32'(bus.byte_ready), 32'd0);
      checkOutput("t3_no_65th",    32'(weCount - we0),  32'd64);
      bus.byte_valid = 1'b0;

      $display("[TB] byte_valid gaps inside a word");
      d0  = doneSeen;
      we0 = weCount;
      sb.push_back(wr_t'{6'd0, 32'h04030201});
      applyStimulus(7'd1, sc);
      sendByte(8'h01, 2);
      sendByte(8'h02, 0);
      sendByte(8'h03, 0);
      sendByte(8'h04, 0);
      waitDone(d0, "t4_done");
      checkOutput("t4_writes",   32'(weCount - we0), 32'd1);
      checkOutput("t4_sb_empty", 32'(sb.size()),     32'd0);

      $display("[TB] reset in the middle of a word");
      we0 = weCount;
      applyStimulus(7'd3, sc);
      sendByte(8'hAA, 0);
      sendByte(8'hBB, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("t5_busy",       32'(bus.busy),       32'd0);
      checkOutput("t5_cpu_stall",  32'(bus.cpu_stall),  32'd0);
      checkOutput("t5_byte_ready", 32'(bus.byte_ready), 32'd0);
      checkOutput("t5_mem_we",     32'(bus.mem_we),     32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("t5_no_write", 32'(weCount - we0), 32'd0);
      d0 = doneSeen;
      sb.push_back(wr_t'{6'd0, 32'hDEADBEEF});
      applyStimulus(7'd1, sc);
      checkOutput("t5_restart_addr", 32'(bus.mem_waddr), 32'd0);
      sendWord(32'hDEADBEEF);
      waitDone(d0, "t5_done");
      checkOutput("t5_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] fetch fault decode while idle");
      @(posedge clk); #1;
      bus.cpu_pc = 8'h40;
      #1;
      checkOutput("t6_fault_40", 32'(bus.fetch_fault), 32'd1);
      bus.cpu_pc = 8'h3F;
      #1;
      checkOutput("t6_fault_3f", 32'(bus.fetch_fault), 32'd0);
      checkOutput("t6_raddr_3f", 32'(bus.mem_raddr),   32'h3F);
      bus.cpu_pc = 8'hFF;
      #1;
      checkOutput("t6_fault_ff", 32'(bus.fetch_fault), 32'd1);

      repeat (2) begin
         @(posedge clk); #1;
      end
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
